mux41_rr_arb: RTL
=================

MUX41_RR_ARB -- requirements
Module: mux41_rr_arb

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the data width of every requester data input and of q.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port req, input, 4 bits: bit i high means requester i holds a valid word on its data input.
REQ-005 Ports X1, X2, X3, X4, input, N bits each: data of requesters 0, 1, 2, 3.
REQ-006 Port ack, output, 4 bits: one-hot, combinational; bit i high in the cycle requester i's word is captured.
REQ-007 Port q, output, N bits: registered selected data.
REQ-008 Port select, output, 2 bits: registered index of the requester whose word is in q.
REQ-009 Port q_valid, output, 1 bit: q and select hold an undelivered word.
REQ-010 Port q_ready, input, 1 bit: consumer accepts q in any cycle where q_valid and q_ready are both high.
REQ-011 Port grant_cnt, output, 16 bits: count of captured words, saturating.

Function
REQ-012 load SHALL equal (q_valid==0 or q_ready==1) and (req != 0).
REQ-013 The winner SHALL be the first set req bit found by searching from index (ptr+1) mod 4 upward with wrap-around; ptr is the 2-bit index of the last winner.
REQ-014 When load is high, ack SHALL have exactly the winner bit set; otherwise ack SHALL be 0000.
REQ-015 On a clock edge with load high, q SHALL take the winner's data (X1..X4 for index 0..3), select SHALL take the winner index, q_valid SHALL become 1, and ptr SHALL take the winner index.
REQ-016 On a clock edge with q_valid and q_ready high and load low, q_valid SHALL become 0; q and select SHALL hold their values.
REQ-017 While q_valid is high and q_ready is low, q, select, q_valid and ptr SHALL hold their values, and ack SHALL be 0000.
REQ-018 A simultaneous drain and capture (q_valid, q_ready and load all high) SHALL deliver the old word and capture the new one in the same edge, sustaining one word per cycle.
REQ-019 Requesters SHALL hold req and data stable until ack; a req deasserted before ack SHALL drop that request without error.
REQ-020 A single continuous requester SHALL be granted every cycle the output register can load.
REQ-021 With all four requesters continuously requesting and q_ready held high, grant order SHALL be 0,1,2,3,0,… with no requester waiting more than 3 captures.
REQ-022 grant_cnt SHALL increment by 1 on every edge with load high, and SHALL saturate at 16'hFFFF.
REQ-023 The control state SHALL be two states: EMPTY (q_valid=0) and FULL (q_valid=1).
REQ-024 EMPTY SHALL go to FULL on load; otherwise it SHALL stay EMPTY.
REQ-025 FULL SHALL stay FULL on load or on not q_ready, and SHALL go to EMPTY on q_ready with no load.

Reset
REQ-026 While rst_n is low, regardless of clk: q_valid=0, q=0, select=00, ptr=11 (so requester 0 has first priority), grant_cnt=0; ack SHALL be 0000.
REQ-027 Reset asserted mid-transfer SHALL discard the word held in q without delivering it.
REQ-028 After rst_n deasserts, the first capture SHALL occur no earlier than the first rising edge at which rst_n is sampled high.

Verification
REQ-029 Reset, then req=1111 with X1..X4 = 1,2,3,4 and q_ready=1 for 8 cycles -> select sequence 0,1,2,3,0,1,2,3; q sequence 1,2,3,4,1,2,3,4; q_valid=1 throughout; grant_cnt=8.
REQ-030 req=0100 with q_ready=0 -> ack=0100 for one cycle only; then q_valid=1, select=2, q=X3 held, ack=0000 until q_ready=1, after which the next capture occurs on that edge.
REQ-031 After winner 3, req=1001 -> next winner 0 (wrap-around); after winner 0, req=1001 -> next winner 3.
REQ-032 Assert rst_n=0 asynchronously while q_valid=1 and between clock edges -> q_valid=0, q=0, select=00, grant_cnt=0 immediately; after release, req=1111 -> first winner 0.
REQ-033 Force grant_cnt to near saturation (65534 captures), then 3 more captures -> grant_cnt reads 65535 and stays there.
REQ-034 Bench SHALL check continuously that ack is one-hot or zero, and that ack is nonzero only when load is high.

Source files
------------

// File: rtl/mux41_rr_arb.sv
// mux41_rr_arb: four-requester round-robin arbiter feeding a one-word
// registered output buffer with a valid/ready handshake toward the consumer.
// A requester is acknowledged in the cycle its word is captured into q.
module mux41_rr_arb #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [N-1:0] X1,
  input  logic [N-1:0] X2,
  input  logic [N-1:0] X3,
  input  logic [N-1:0] X4,
  output logic [3:0]   ack,
  output logic [N-1:0] q,
  output logic [1:0]   select,
  output logic         q_valid,
  input  logic         q_ready,
  output logic [15:0]  grant_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [1:0]     ptr_r;
  logic [1:0]     win_s;
  logic           load_s;
  logic [N-1:0]   win_data_s;

  // First set request bit after ptr, wrapping; the last winner is checked last.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + k[1:0];
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Load when the buffer can take a word and someone is asking; ack is held
  // off during reset so no requester sees a grant that will not be captured.
  always_comb begin
    load_s = rst_n && ((state_r == EMPTY) || q_ready) && (req != 4'b0000);
    win_s  = rr_pick(ptr_r, req);
    ack    = 4'b0000;
    if (load_s) begin
      ack = 4'b0001 << win_s;
    end else begin
      ack = 4'b0000;
    end
  end

  // Data mux selecting the winner's word.
  always_comb begin
    win_data_s = X1;
    case (win_s)
      2'd0:    win_data_s = X1;
      2'd1:    win_data_s = X2;
      2'd2:    win_data_s = X3;
      2'd3:    win_data_s = X4;
      default: win_data_s = X1;
    endcase
  end

  // Buffer occupancy: a capture always leaves it full, a drain without a
  // capture empties it, otherwise it holds.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (load_s) state_nxt_s = FULL;
        else        state_nxt_s = EMPTY;
      end
      FULL: begin
        if (load_s)       state_nxt_s = FULL;
        else if (q_ready) state_nxt_s = EMPTY;
        else              state_nxt_s = FULL;
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Occupancy state register; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= EMPTY;
    else        state_r <= state_nxt_s;
  end

  // Output word, index, round-robin pointer and saturating capture counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      select    <= 2'b00;
      ptr_r     <= 2'b11;
      grant_cnt <= 16'h0000;
    end else if (load_s) begin
      q         <= win_data_s;
      select    <= win_s;
      ptr_r     <= win_s;
      grant_cnt <= (grant_cnt == 16'hFFFF) ? grant_cnt : (grant_cnt + 16'd1);
    end else begin
      q         <= q;
      select    <= select;
      ptr_r     <= ptr_r;
      grant_cnt <= grant_cnt;
    end
  end

  assign q_valid = (state_r == FULL);

endmodule
